// File: rtl/mdio_slave_c22_c45_ovs.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_slave_c22_c45_ovs                                                   |
// | Oversampled MDIO slave (clause 22 / clause 45) on the clk_25m domain.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mdio_slave_c22_c45_ovs #(
  parameter int PRE_MIN     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int C45_EN      = 1
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        enable,
  input  logic        opendrain_mode,
  input  logic [4:0]  legal_phy_addr,
  input  logic [4:0]  legal_phy_addr_mask,
  input  logic [4:0]  broadcast_addr,
  input  logic        broadcast_mode,
  output logic        req_valid,
  output logic        req_c45,
  output logic [1:0]  req_op,
  output logic [4:0]  req_prtad,
  output logic [4:0]  req_regad,
  output logic [15:0] req_wdata,
  input  logic        resp_valid,
  input  logic [15:0] resp_rdata,
  output logic        frame_err
);

  localparam logic [6:0] c_PRE_MIN = 7'(PRE_MIN);

  typedef enum logic [3:0] {
    S_IDLE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_WDATA, S_RDATA, S_SKIP
  } state_t;

  logic [SYNC_STAGES-1:0] r_mdc_sync, r_mdio_sync;
  logic                   r_mdc_d;
  logic                   w_mdc_rise, w_mdio;

  state_t      r_state, w_state_nx;
  logic [4:0]  r_bit_cnt, w_bit_cnt_nx;
  logic [5:0]  r_pre_cnt, w_pre_cnt_nx;
  logic        r_c45, w_c45_nx;
  logic [1:0]  r_op, w_op_nx;
  logic [4:0]  r_prtad_sh, w_prtad_nx;
  logic [4:0]  r_regad_sh, w_regad_nx;
  logic [15:0] r_data_sh, w_data_nx;
  logic        r_ta1, w_ta1_nx;
  logic        r_rd, w_rd_nx;
  logic        r_resp_seen, w_resp_seen_nx;
  logic        r_oe_int, w_oe_int_nx;
  logic        r_mdio_out, w_out_nx;
  logic        r_mdio_oe;
  logic        r_req_valid, w_req_valid_nx;
  logic        r_frame_err, w_frame_err_nx;
  logic        r_req_c45, w_req_c45_nx;
  logic [1:0]  r_req_op, w_req_op_nx;
  logic [4:0]  r_req_prtad, w_req_prtad_nx;
  logic [4:0]  r_req_regad, w_req_regad_nx;
  logic [15:0] r_req_wdata, w_req_wdata_nx;

  logic        w_pre_ok, w_own_hit, w_bcast_hit, w_is_read, w_is_write, w_resp_ok;
  logic [15:0] w_rd_word;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_mdc_sync  <= '0;
      r_mdio_sync <= '0;
      r_mdc_d     <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], mdc};
      r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], mdio_in};
      r_mdc_d     <= r_mdc_sync[SYNC_STAGES-1];
    end
  end

  assign w_mdc_rise = r_mdc_sync[SYNC_STAGES-1] & ~r_mdc_d;
  assign w_mdio     = r_mdio_sync[SYNC_STAGES-1];

  // pre_cnt >= PRE_MIN written so it never degenerates to a constant compare
  assign w_pre_ok    = ({1'b0, r_pre_cnt} + 7'd1) > c_PRE_MIN;
  assign w_own_hit   = ((r_prtad_sh ^ legal_phy_addr) & legal_phy_addr_mask) == 5'd0;
  assign w_bcast_hit = broadcast_mode && (r_prtad_sh == broadcast_addr);
  assign w_is_read   = r_c45 ? r_op[1]  : (r_op == 2'b10);
  assign w_is_write  = r_c45 ? ~r_op[1] : (r_op == 2'b01);
  assign w_resp_ok   = r_resp_seen | resp_valid;
  assign w_rd_word   = w_resp_ok ? resp_rdata : 16'hFFFF;

  always_comb begin
    w_state_nx      = r_state;
    w_bit_cnt_nx    = r_bit_cnt;
    w_pre_cnt_nx    = r_pre_cnt;
    w_c45_nx        = r_c45;
    w_op_nx         = r_op;
    w_prtad_nx      = r_prtad_sh;
    w_regad_nx      = r_regad_sh;
    w_data_nx       = r_data_sh;
    w_ta1_nx        = r_ta1;
    w_rd_nx         = r_rd;
    w_resp_seen_nx  = r_resp_seen | resp_valid;
    w_oe_int_nx     = r_oe_int;
    w_out_nx        = r_mdio_out;
    w_req_valid_nx  = 1'b0;
    w_frame_err_nx  = 1'b0;
    w_req_c45_nx    = r_req_c45;
    w_req_op_nx     = r_req_op;
    w_req_prtad_nx  = r_req_prtad;
    w_req_regad_nx  = r_req_regad;
    w_req_wdata_nx  = r_req_wdata;

    if (!enable) begin
      w_state_nx   = S_IDLE;
      w_pre_cnt_nx = 6'd0;
      w_bit_cnt_nx = 5'd0;
      w_oe_int_nx  = 1'b0;
      w_out_nx     = 1'b1;
    end else if (w_mdc_rise) begin
      // bit counter holds the frame index (0..31) of the bit being sampled
      w_bit_cnt_nx = r_bit_cnt + 5'd1;
      case (r_state)
        S_IDLE: begin
          w_bit_cnt_nx = 5'd0;
          if (w_mdio) begin
            if (r_pre_cnt < 6'd32) w_pre_cnt_nx = r_pre_cnt + 6'd1;
          end else begin
            w_pre_cnt_nx = 6'd0;
            if (w_pre_ok) begin
              w_state_nx   = S_ST;
              w_bit_cnt_nx = 5'd1;
            end
          end
        end
        S_ST: begin
          if (w_mdio) begin
            w_c45_nx   = 1'b0;
            w_state_nx = S_OP;
          end else if (C45_EN != 0) begin
            w_c45_nx   = 1'b1;
            w_state_nx = S_OP;
          end else begin
            w_state_nx = S_SKIP;
          end
        end
        S_OP: begin
          w_op_nx = {r_op[0], w_mdio};
          if (r_bit_cnt == 5'd3) w_state_nx = S_PHY;
        end
        S_PHY: begin
          w_prtad_nx = {r_prtad_sh[3:0], w_mdio};
          if (r_bit_cnt == 5'd8) w_state_nx = S_REG;
        end
        S_REG: begin
          w_regad_nx = {r_regad_sh[3:0], w_mdio};
          if (r_bit_cnt == 5'd13) begin
            w_rd_nx = 1'b0;
            if (w_is_read && w_own_hit && !w_bcast_hit) begin
              w_rd_nx        = 1'b1;
              w_resp_seen_nx = 1'b0;
              w_req_valid_nx = 1'b1;
              w_req_c45_nx   = r_c45;
              w_req_op_nx    = r_op;
              w_req_prtad_nx = r_prtad_sh;
              w_req_regad_nx = w_regad_nx;
              w_req_wdata_nx = 16'h0000;
              w_state_nx     = S_TA;
            end else if (w_is_write && (w_own_hit || w_bcast_hit)) begin
              w_state_nx = S_TA;
            end else begin
              w_state_nx = S_SKIP;
            end
          end
        end
        S_TA: begin
          if (r_bit_cnt == 5'd14) begin
            if (r_rd) begin
              w_oe_int_nx = 1'b1;
              w_out_nx    = 1'b0;
            end else begin
              w_ta1_nx = w_mdio;
            end
          end else if (r_rd) begin
            w_frame_err_nx = ~w_resp_ok;
            w_out_nx       = w_rd_word[15];
            w_data_nx      = {w_rd_word[14:0], 1'b0};
            w_state_nx     = S_RDATA;
          end else if ({r_ta1, w_mdio} == 2'b10) begin
            w_state_nx = S_WDATA;
          end else begin
            w_frame_err_nx = 1'b1;
            w_state_nx     = S_SKIP;
          end
        end
        S_WDATA: begin
          w_data_nx = {r_data_sh[14:0], w_mdio};
          if (r_bit_cnt == 5'd31) begin
            w_req_valid_nx = 1'b1;
            w_req_c45_nx   = r_c45;
            w_req_op_nx    = r_op;
            w_req_prtad_nx = r_prtad_sh;
            w_req_regad_nx = r_regad_sh;
            w_req_wdata_nx = w_data_nx;
            w_state_nx     = S_IDLE;
          end
        end
        S_RDATA: begin
          if (r_bit_cnt == 5'd31) begin
            w_oe_int_nx = 1'b0;
            w_out_nx    = 1'b1;
            w_state_nx  = S_IDLE;
          end else begin
            w_out_nx  = r_data_sh[15];
            w_data_nx = {r_data_sh[14:0], 1'b0};
          end
        end
        S_SKIP: begin
          if (r_bit_cnt == 5'd31) w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 5'd0;
      r_pre_cnt   <= 6'd0;
      r_c45       <= 1'b0;
      r_op        <= 2'd0;
      r_prtad_sh  <= 5'd0;
      r_regad_sh  <= 5'd0;
      r_data_sh   <= 16'd0;
      r_ta1       <= 1'b0;
      r_rd        <= 1'b0;
      r_resp_seen <= 1'b0;
      r_oe_int    <= 1'b0;
      r_mdio_out  <= 1'b1;
      r_mdio_oe   <= 1'b0;
      r_req_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_req_c45   <= 1'b0;
      r_req_op    <= 2'd0;
      r_req_prtad <= 5'd0;
      r_req_regad <= 5'd0;
      r_req_wdata <= 16'd0;
    end else begin
      r_state     <= w_state_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_pre_cnt   <= w_pre_cnt_nx;
      r_c45       <= w_c45_nx;
      r_op        <= w_op_nx;
      r_prtad_sh  <= w_prtad_nx;
      r_regad_sh  <= w_regad_nx;
      r_data_sh   <= w_data_nx;
      r_ta1       <= w_ta1_nx;
      r_rd        <= w_rd_nx;
      r_resp_seen <= w_resp_seen_nx;
      r_oe_int    <= w_oe_int_nx;
      r_mdio_out  <= w_out_nx;
      // enable is registered from the next values so the pin never glitches
      r_mdio_oe   <= w_oe_int_nx & (~opendrain_mode | ~w_out_nx);
      r_req_valid <= w_req_valid_nx;
      r_frame_err <= w_frame_err_nx;
      r_req_c45   <= w_req_c45_nx;
      r_req_op    <= w_req_op_nx;
      r_req_prtad <= w_req_prtad_nx;
      r_req_regad <= w_req_regad_nx;
      r_req_wdata <= w_req_wdata_nx;
    end
  end

  assign mdio_out  = r_mdio_out;
  assign mdio_oe   = r_mdio_oe;
  assign req_valid = r_req_valid;
  assign frame_err = r_frame_err;
  assign req_c45   = r_req_c45;
  assign req_op    = r_req_op;
  assign req_prtad = r_req_prtad;
  assign req_regad = r_req_regad;
  assign req_wdata = r_req_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mdio_slave_c22_c45_ovs.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdio_slave_c22_c45_ovs                                                |
// | Directed bench: MDIO master model driving two slaves (PRE_MIN 32 and 0). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mdio_slave_c22_c45_ovs;

  logic clk_25m = 1'b0;
  logic rst_n = 1'b0;
  logic mdc = 1'b0;
  logic mdio_in = 1'b1;
  logic enable = 1'b1;
  logic opendrain_mode = 1'b0;
  logic [4:0] legal_phy_addr = 5'h03;
  logic [4:0] legal_phy_addr_mask = 5'h1F;
  logic [4:0] broadcast_addr = 5'h1F;
  logic broadcast_mode = 1'b0;
  logic resp_valid;
  logic [15:0] resp_rdata;

  logic mdio_out, mdio_oe, req_valid, req_c45, frame_err;
  logic [1:0] req_op;
  logic [4:0] req_prtad, req_regad;
  logic [15:0] req_wdata;
  logic mdio_out2, mdio_oe2, req_valid2, req_c452, frame_err2;
  logic [1:0] req_op2;
  logic [4:0] req_prtad2, req_regad2;
  logic [15:0] req_wdata2;

  always #20 clk_25m = ~clk_25m;

  mdio_slave_c22_c45_ovs dut (
    .clk_25m(clk_25m), .rst_n(rst_n), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe), .enable(enable),
    .opendrain_mode(opendrain_mode), .legal_phy_addr(legal_phy_addr),
    .legal_phy_addr_mask(legal_phy_addr_mask), .broadcast_addr(broadcast_addr),
    .broadcast_mode(broadcast_mode), .req_valid(req_valid), .req_c45(req_c45),
    .req_op(req_op), .req_prtad(req_prtad), .req_regad(req_regad),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .frame_err(frame_err)
  );

  mdio_slave_c22_c45_ovs #(.PRE_MIN(0)) dut_np (
    .clk_25m(clk_25m), .rst_n(rst_n), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out2), .mdio_oe(mdio_oe2), .enable(enable),
    .opendrain_mode(opendrain_mode), .legal_phy_addr(legal_phy_addr),
    .legal_phy_addr_mask(legal_phy_addr_mask), .broadcast_addr(broadcast_addr),
    .broadcast_mode(broadcast_mode), .req_valid(req_valid2), .req_c45(req_c452),
    .req_op(req_op2), .req_prtad(req_prtad2), .req_regad(req_regad2),
    .req_wdata(req_wdata2), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .frame_err(frame_err2)
  );

  localparam logic [31:0] c_W22 = {2'b01, 2'b01, 5'h03, 5'h04, 2'b10, 16'hABCD};
  localparam logic [31:0] c_R22 = {2'b01, 2'b10, 5'h03, 5'h04, 2'b11, 16'hFFFF};
  localparam logic [31:0] c_A45 = {2'b00, 2'b00, 5'h03, 5'h04, 2'b10, 16'h0010};
  localparam logic [31:0] c_R45 = {2'b00, 2'b11, 5'h03, 5'h04, 2'b11, 16'hFFFF};
  localparam logic [31:0] c_BR  = {2'b01, 2'b10, 5'h1F, 5'h04, 2'b11, 16'hFFFF};
  localparam logic [31:0] c_BW  = {2'b01, 2'b01, 5'h1F, 5'h02, 2'b10, 16'h1357};
  localparam logic [31:0] c_WTA = {2'b01, 2'b01, 5'h03, 5'h04, 2'b11, 16'hABCD};
  localparam logic [31:0] c_W2  = {2'b01, 2'b01, 5'h03, 5'h07, 2'b10, 16'h55AA};

  int n_assert = 0;
  int n_fail = 0;

  // Event monitor: request/error pulse counts and last captured request
  int rv_cnt = 0, rv2_cnt = 0, fe_cnt = 0, oe_cyc = 0;
  logic [31:0] cap = '0, cap2 = '0;
  always @(negedge clk_25m) begin
    if (req_valid) begin
      rv_cnt <= rv_cnt + 1;
      cap <= {3'b0, req_c45, req_op, req_prtad, req_regad, req_wdata};
    end
    if (req_valid2) begin
      rv2_cnt <= rv2_cnt + 1;
      cap2 <= {3'b0, req_c452, req_op2, req_prtad2, req_regad2, req_wdata2};
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (mdio_oe) oe_cyc <= oe_cyc + 1;
  end

  // Read responder: answers about one mdc period after a read request
  logic resp_en = 1'b1;
  logic [15:0] resp_data = 16'h0000;
  initial begin
    resp_valid = 1'b0;
    resp_rdata = 16'h0000;
    forever begin
      @(negedge clk_25m);
      if (((req_valid && req_op[1]) || (req_valid2 && req_op2[1])) && resp_en) begin
        repeat (12) @(negedge clk_25m);
        resp_rdata = resp_data;
        resp_valid = 1'b1;
        @(negedge clk_25m);
        resp_valid = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic smp_out, smp_oe, smp_out2, smp_oe2;
  logic s_out[32], s_oe[32], s_out2[32], s_oe2[32];

  // One mdc period; line values are sampled just before the rising edge
  task automatic mbit(input logic b);
    @(negedge clk_25m);
    mdio_in = b;
    repeat (5) @(negedge clk_25m);
    smp_out = mdio_out;  smp_oe = mdio_oe;
    smp_out2 = mdio_out2; smp_oe2 = mdio_oe2;
    mdc = 1'b1;
    repeat (6) @(negedge clk_25m);
    mdc = 1'b0;
  endtask

  task automatic frame(input int npre, input logic [31:0] f);
    repeat (npre) mbit(1'b1);
    for (int k = 0; k < 32; k++) begin
      mbit(f[31-k]);
      s_out[k] = smp_out;   s_oe[k] = smp_oe;
      s_out2[k] = smp_out2; s_oe2[k] = smp_oe2;
    end
    mdio_in = 1'b1;
    repeat (4) @(negedge clk_25m);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ecap(input logic c45, input logic [1:0] op,
                                       input logic [4:0] pa, input logic [4:0] ra,
                                       input logic [15:0] wd);
    return {3'b0, c45, op, pa, ra, wd};
  endfunction

  logic [15:0] rword, rword2;
  logic [16:0] oev;
  int b_rv, b_rv2, b_fe, b_oe;

  task automatic gather;
    for (int i = 0; i < 16; i++) begin
      rword[15-i]  = s_out[16+i];
      rword2[15-i] = s_out2[16+i];
    end
    for (int i = 0; i < 17; i++) oev[16-i] = s_oe[15+i];
  endtask

  task automatic base;
    b_rv = rv_cnt; b_rv2 = rv2_cnt; b_fe = fe_cnt; b_oe = oe_cyc;
  endtask

  initial begin
    repeat (5) @(negedge clk_25m);
    check("reset_oe", 32'(mdio_oe), 32'd0);
    check("reset_out", 32'(mdio_out), 32'd1);
    check("reset_req", 32'({req_valid, frame_err, req_prtad, req_wdata}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_25m);

    // PRE_MIN=0 slave: C45 address then read without preamble
    base();
    resp_data = 16'h5A5A;
    frame(0, c_A45);
    check("np_addr_cap", cap2, ecap(1'b1, 2'b00, 5'h03, 5'h04, 16'h0010));
    frame(0, c_R45);
    gather();
    check("np_req_cnt", 32'(rv2_cnt - b_rv2), 32'd2);
    check("np_read_cap", cap2, ecap(1'b1, 2'b11, 5'h03, 5'h04, 16'h0000));
    check("np_read_data", 32'(rword2), 32'h5A5A);
    check("nopre_ignored", 32'(rv_cnt - b_rv), 32'd0);

    // C22 write
    base();
    frame(32, c_W22);
    check("c22w_cnt", 32'(rv_cnt - b_rv), 32'd1);
    check("c22w_cap", cap, ecap(1'b0, 2'b01, 5'h03, 5'h04, 16'hABCD));

    // C22 read
    base();
    resp_data = 16'h1234;
    frame(32, c_R22);
    gather();
    mbit(1'b1);
    check("c22r_cnt", 32'(rv_cnt - b_rv), 32'd1);
    check("c22r_cap", cap, ecap(1'b0, 2'b10, 5'h03, 5'h04, 16'h0000));
    check("c22r_oe_pre_ta", 32'(s_oe[14]), 32'd0);
    check("c22r_ta_drive", 32'({s_oe[15], s_out[15]}), 32'b10);
    check("c22r_data", 32'(rword), 32'h1234);
    check("c22r_oe_span", 32'(oev), 32'h1FFFF);
    check("c22r_oe_release", 32'(smp_oe), 32'd0);
    check("c22r_no_err", 32'(fe_cnt - b_fe), 32'd0);

    // C45 address then read on the PRE_MIN=32 slave
    base();
    resp_data = 16'hBEEF;
    frame(32, c_A45);
    check("c45a_cap", cap, ecap(1'b1, 2'b00, 5'h03, 5'h04, 16'h0010));
    frame(32, c_R45);
    gather();
    check("c45_cnt", 32'(rv_cnt - b_rv), 32'd2);
    check("c45r_cap", cap, ecap(1'b1, 2'b11, 5'h03, 5'h04, 16'h0000));
    check("c45r_data", 32'(rword), 32'hBEEF);

    // read with no response
    base();
    resp_en = 1'b0;
    frame(32, c_R22);
    gather();
    resp_en = 1'b1;
    check("noresp_data", 32'(rword), 32'hFFFF);
    check("noresp_err", 32'(fe_cnt - b_fe), 32'd1);
    check("noresp_req", 32'(rv_cnt - b_rv), 32'd1);

    // broadcast read is skipped, broadcast write is accepted
    broadcast_mode = 1'b1;
    base();
    frame(32, c_BR);
    check("bcast_rd_req", 32'(rv_cnt - b_rv), 32'd0);
    check("bcast_rd_oe", 32'(oe_cyc - b_oe), 32'd0);
    frame(32, c_BW);
    check("bcast_wr_cap", cap, ecap(1'b0, 2'b01, 5'h1F, 5'h02, 16'h1357));
    broadcast_mode = 1'b0;

    // bad turnaround on a write
    base();
    frame(32, c_WTA);
    check("bad_ta_err", 32'(fe_cnt - b_fe), 32'd1);
    check("bad_ta_req", 32'(rv_cnt - b_rv), 32'd0);

    // short preamble
    base();
    frame(20, c_W22);
    check("short_pre", 32'(rv_cnt - b_rv), 32'd0);

    // enable drop in the middle of read data
    repeat (32) mbit(1'b1);
    for (int k = 0; k < 21; k++) mbit(c_R22[31-k]);
    check("abort_oe_before", 32'(smp_oe), 32'd1);
    @(negedge clk_25m);
    enable = 1'b0;
    @(negedge clk_25m);
    check("abort_oe_after", 32'(mdio_oe), 32'd0);
    repeat (4) @(negedge clk_25m);
    enable = 1'b1;
    repeat (4) @(negedge clk_25m);
    base();
    frame(32, c_W2);
    check("reenable_cap", cap, ecap(1'b0, 2'b01, 5'h03, 5'h07, 16'h55AA));
    check("reenable_cnt", 32'(rv_cnt - b_rv), 32'd1);

    // open-drain read: enable only on driven zeros
    opendrain_mode = 1'b1;
    resp_data = 16'hA5C3;
    frame(32, c_R22);
    gather();
    check("od_data", 32'(rword), 32'hA5C3);
    check("od_oe", 32'(oev), 32'({1'b1, 16'h5A3C}));
    opendrain_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
